// File: rtl/btb_pkg.sv
// Shared types for the set-associative branch target buffer: entry view, 2-bit
// direction counter encodings and their saturating update helpers.
package btb_pkg;

  typedef enum logic [1:0] {
    CtrStrongNt = 2'b00,
    CtrWeakNt   = 2'b01,
    CtrWeakT    = 2'b10,
    CtrStrongT  = 2'b11
  } ctr_e;

  // Widest partial tag any configuration can store (pc[31:2]).
  localparam int unsigned TagMaxW = 30;
  typedef logic [TagMaxW-1:0] tag_t;

  typedef struct packed {
    tag_t        tag;
    logic [31:0] target;
    ctr_e        ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_inc(ctr_e c);
    case (c)
      CtrStrongNt: return CtrWeakNt;
      CtrWeakNt:   return CtrWeakT;
      CtrWeakT:    return CtrStrongT;
      default:     return CtrStrongT;
    endcase
  endfunction

  function automatic ctr_e ctr_dec(ctr_e c);
    case (c)
      CtrStrongT: return CtrWeakT;
      CtrWeakT:   return CtrWeakNt;
      CtrWeakNt:  return CtrStrongNt;
      default:    return CtrStrongNt;
    endcase
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Picks the way to allocate in one set: lowest-numbered invalid way, otherwise
// the way named by the set's round-robin pointer.
module btb_victim_sel #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [WAYS-1:0]  valid_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] victim_o,
  output logic             full_o
);

  always_comb begin
    victim_o = ptr_i;
    full_o   = &valid_i;
    // Scan downward so the lowest invalid way wins.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o = PTR_W'(w);
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with 2-bit direction counters: combinational fetch lookup,
// EX-stage update/allocate with round-robin replacement, and a global flush.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned WAYS    = 2,
  parameter int unsigned TAG_W   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  output logic        hit_if,
  output logic        taken_if,
  output logic [31:0] target_if,
  input  logic        update_en,
  input  logic [31:0] pc_ex,
  input  logic [31:0] target_ex,
  input  logic        taken_ex,
  input  logic        flush
);

  localparam int unsigned SETS  = ENTRIES / WAYS;
  localparam int unsigned SET_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TAG_LO = SET_W + 2;
  localparam int unsigned TAG_HI = SET_W + TAG_W + 1;

  // Storage. Only valid bits, counters and pointers are reset.
  logic [WAYS-1:0]  valid_q  [SETS];
  ctr_e             ctr_q    [SETS][WAYS];
  logic [TAG_W-1:0] tag_q    [SETS][WAYS];
  logic [31:0]      target_q [SETS][WAYS];
  logic [PTR_W-1:0] ptr_q    [SETS];

  logic [SET_W-1:0] lk_set, up_set;
  logic [TAG_W-1:0] lk_tag, up_tag;

  assign lk_set = pc_if[SET_W+1:2];
  assign lk_tag = pc_if[TAG_HI:TAG_LO];
  assign up_set = pc_ex[SET_W+1:2];
  assign up_tag = pc_ex[TAG_HI:TAG_LO];

  logic unused_pc;
  assign unused_pc = ^{pc_if[1:0], pc_if[31:TAG_HI+1], pc_ex[1:0], pc_ex[31:TAG_HI+1]};

  // Fetch-side lookup
  btb_entry_t      lk_ent [WAYS];
  logic [WAYS-1:0] lk_match;
  logic [31:0]     lk_target;
  logic [1:0]      lk_ctr;

  always_comb begin
    lk_match  = '0;
    lk_target = '0;
    lk_ctr    = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      lk_ent[w] = '{tag:    tag_t'(tag_q[lk_set][w]),
                    target: target_q[lk_set][w],
                    ctr:    ctr_q[lk_set][w]};
      lk_match[w] = valid_q[lk_set][w] && (lk_ent[w].tag == tag_t'(lk_tag));
      // At most one way can match, so a plain priority pick is exact.
      if (lk_match[w]) begin
        lk_target = lk_ent[w].target;
        lk_ctr    = lk_ent[w].ctr;
      end
    end
  end

  assign hit_if    = |lk_match;
  assign taken_if  = hit_if & lk_ctr[1];
  assign target_if = lk_target;

  // EX-side update
  logic [WAYS-1:0]  up_match;
  logic             up_hit;
  logic [PTR_W-1:0] hit_way, victim_way, wr_way;
  logic             set_full;
  logic             upd_live, alloc, ctr_we, ptr_adv, ent_we;
  ctr_e             wr_ctr;

  always_comb begin
    up_match = '0;
    hit_way  = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      up_match[w] = valid_q[up_set][w] && (tag_q[up_set][w] == up_tag);
      if (up_match[w]) begin
        hit_way = PTR_W'(w);
      end
    end
  end

  assign up_hit = |up_match;

  btb_victim_sel #(
    .WAYS  (WAYS),
    .PTR_W (PTR_W)
  ) u_victim_sel (
    .valid_i  (valid_q[up_set]),
    .ptr_i    (ptr_q[up_set]),
    .victim_o (victim_way),
    .full_o   (set_full)
  );

  assign upd_live = update_en & ~flush;
  assign alloc    = upd_live & ~up_hit & taken_ex;
  assign ctr_we   = upd_live & (up_hit | taken_ex);
  assign wr_way   = up_hit ? hit_way : victim_way;
  assign ptr_adv  = alloc & set_full & (WAYS > 1);
  // Tag/target have no reset, so gate their write on rst_n to drop updates under reset.
  assign ent_we   = rst_n & upd_live & taken_ex;

  always_comb begin
    wr_ctr = CtrWeakT;
    if (up_hit) begin
      wr_ctr = taken_ex ? ctr_inc(ctr_q[up_set][hit_way]) : ctr_dec(ctr_q[up_set][hit_way]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          ctr_q[s][w] <= CtrStrongNt;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
      end
    end else begin
      if (alloc) begin
        valid_q[up_set][wr_way] <= 1'b1;
      end
      if (ctr_we) begin
        ctr_q[up_set][wr_way] <= wr_ctr;
      end
      if (ptr_adv) begin
        ptr_q[up_set] <= ptr_q[up_set] + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ent_we) begin
      tag_q[up_set][wr_way]    <= up_tag;
      target_q[up_set][wr_way] <= target_ex;
    end
  end

endmodule
